// File: rtl/uart_line_buffer.sv
// uart_line_buffer
// Collects bytes from the UART receiver into a line buffer until an
// end-of-line byte arrives or the buffer fills, then replays the whole line
// in order to the UART transmitter. This turns per-byte echo into per-line
// echo.
//
// Handshake (both sides): a byte moves on a rising sys_clk edge where
// valid and ready are both 1. The producer holds data and valid stable until
// that edge. On the rx side, bytes offered while ready=0 are dropped
// upstream. On the tx side, tx_data/tx_data_valid stay stable until
// tx_data_ready is seen.
//
// Sequencing: FILL accepts bytes. FETCH does a registered read of the next
// stored byte into tx_data. SEND waits for the transmitter. Each replayed
// byte therefore costs at least one idle cycle (FETCH) between handshakes.
// state_dbg exposes the FSM state for observation.

module uart_line_buffer #(
    parameter int         DEPTH  = 64,
    parameter int         ADDR_W = 6,
    parameter logic [7:0] EOL    = 8'h0A
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ready,
    output logic [ADDR_W:0]   line_len,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    // Counter compares are done one bit wider than the counters so that
    // DEPTH-1 and line_len-1 never alias with a wrapped value.
    localparam int               LAST_WR_I = DEPTH - 1;
    localparam logic [ADDR_W:0]  LAST_WR   = LAST_WR_I[ADDR_W:0];
    localparam logic [ADDR_W:0]  LEN_ONE   = 1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [7:0]        mem [DEPTH];

    logic [ADDR_W:0]   wr_ext;
    logic [ADDR_W:0]   rd_ext;
    logic              rx_fire;
    logic              is_eol;
    logic              wr_full;
    logic              line_close;
    logic              tx_fire;
    logic              rd_last;

    // Decode of handshakes and line/replay boundary conditions.
    always_comb begin
        wr_ext     = {1'b0, wr_cnt};
        rd_ext     = {1'b0, rd_cnt};
        rx_fire    = (state_q == FILL) && rx_data_valid;
        is_eol     = (rx_data == EOL);
        wr_full    = (wr_ext == LAST_WR);
        line_close = rx_fire && (is_eol || wr_full);
        tx_fire    = (state_q == SEND) && tx_data_ready;
        rd_last    = (rd_ext == (line_len - LEN_ONE));
    end

    // Status outputs are pure functions of the state register.
    always_comb begin
        rx_data_ready = (state_q == FILL);
        busy          = (state_q != FILL);
        state_dbg     = state_q;
    end

    // FSM state register; reset discards any line in progress.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (line_close) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = SEND;
            end
            SEND: begin
                if (tx_fire) begin
                    state_d = rd_last ? FILL : FETCH;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Counters, line length, overflow pulse and the registered tx byte.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            line_len      <= '0;
            overflow      <= 1'b0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state_q)
                FILL: begin
                    if (rx_fire) begin
                        if (line_close) begin
                            // An EOL that lands in the last slot is a normal
                            // line end, so overflow only flags a non-EOL close.
                            line_len <= wr_ext + LEN_ONE;
                            wr_cnt   <= '0;
                            rd_cnt   <= '0;
                            overflow <= !is_eol;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end
                    end
                end
                FETCH: begin
                    tx_data       <= mem[rd_cnt];
                    tx_data_valid <= 1'b1;
                end
                SEND: begin
                    if (tx_fire) begin
                        tx_data_valid <= 1'b0;
                        if (!rd_last) begin
                            rd_cnt <= rd_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    tx_data_valid <= 1'b0;
                end
            endcase
        end
    end

    // Line storage; contents are don't-care after reset.
    always_ff @(posedge sys_clk) begin
        if (rx_fire) begin
            mem[wr_cnt] <= rx_data;
        end
    end

endmodule
